conv_mem_responder: RTL and testbench



---
 rtl/conv_mem_responder_pkg.sv | 34 +++
 rtl/conv_mem_responder_if.sv | 40 ++++
 rtl/conv_mem_responder_sp_ram.sv | 41 ++++
 rtl/conv_mem_responder.sv | 181 ++++++++++++++++++
 tb/tb_conv_mem_responder.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_mem_pkg
// Purpose  : Shared widths, bank-select codes and FSM state encoding for the
//            CNN accelerator memory responder.
// Contents : CM_* default widths, CSEL_* bank codes, state_t.
// Revision : 1.0  initial release
// ============================================================================
package conv_mem_pkg;

    localparam int CM_DW      = 20;      // 4.16 signed fixed point
    localparam int CM_IMG_AW  = 12;      // image and L0 banks, 4096 words
    localparam int CM_L1_AW   = 10;      // L1 banks, 1024 words
    localparam int CM_L2_AW   = 11;      // L2 bank, 2048 words
    localparam int CM_TIMEOUT = 100000;  // RUN cycles before forced DONE
    localparam int CYC_W      = 20;      // width of the run-cycle counter

    // Bank-select codes shared by csel and rd_sel; 6 and 7 are illegal.
    localparam logic [2:0] CSEL_NONE = 3'd0;
    localparam logic [2:0] CSEL_L0K0 = 3'd1;
    localparam logic [2:0] CSEL_L0K1 = 3'd2;
    localparam logic [2:0] CSEL_L1K0 = 3'd3;
    localparam logic [2:0] CSEL_L1K1 = 3'd4;
    localparam logic [2:0] CSEL_L2   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/conv_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_mem_if
// Purpose  : Accelerator-side bus between the CNN core (master) and the
//            memory responder (slave): start handshake, image read port and
//            layer-memory read/write ports.
// Ports    : ready/busy handshake, iaddr/idata image read,
//            csel/cwr/caddr_wr/cdata_wr layer write,
//            crd/caddr_rd/cdata_rd layer read.
// Revision : 1.0  initial release
// ============================================================================
interface conv_mem_if
    import conv_mem_pkg::*;
#(
    parameter int DW = CM_DW,
    parameter int AW = CM_IMG_AW
);
    logic          ready;
    logic          busy;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] idata;
    logic [2:0]    csel;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd;

    modport master (
        input  ready, idata, cdata_rd,
        output busy, iaddr, csel, cwr, caddr_wr, cdata_wr, crd, caddr_rd
    );

    modport slave (
        output ready, idata, cdata_rd,
        input  busy, iaddr, csel, cwr, caddr_wr, cdata_wr, crd, caddr_rd
    );
endinterface
`default_nettype wire

// File: rtl/conv_mem_responder_sp_ram.sv
`default_nettype none
// ============================================================================
// Module   : conv_sp_ram
// Purpose  : 2**AW x DW storage with one synchronous write port, one
//            combinational (accelerator) read port and one registered (host)
//            read port. Contents are never reset.
// Ports    : clk; i_we/i_waddr/i_wdata write; i_araddr -> o_ardata (comb);
//            i_hre/i_hraddr -> o_hrdata (one cycle later).
// Revision : 1.0  initial release
// ============================================================================
module conv_sp_ram #(
    parameter int AW = 12,
    parameter int DW = 20
) (
    input  wire logic          clk,
    input  wire logic          i_we,
    input  wire logic [AW-1:0] i_waddr,
    input  wire logic [DW-1:0] i_wdata,
    input  wire logic [AW-1:0] i_araddr,
    output logic      [DW-1:0] o_ardata,
    input  wire logic          i_hre,
    input  wire logic [AW-1:0] i_hraddr,
    output logic      [DW-1:0] o_hrdata
);
    logic [DW-1:0] r_mem [0:(2**AW)-1];
    logic [DW-1:0] r_hrdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_hre) begin
            r_hrdata <= r_mem[i_hraddr];
        end
    end

    // Combinational read sees the pre-edge contents during a same-cycle write.
    assign o_ardata = r_mem[i_araddr];
    assign o_hrdata = r_hrdata;
endmodule
`default_nettype wire

// File: rtl/conv_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : conv_mem_responder
// Purpose  : Synthesizable far-side memory/handshake responder for the CNN
//            accelerator: image store, five layer banks, host load/readback
//            and the IDLE/READY/RUN/DONE launch sequencer.
// Ports    : clk, reset (sync, active-low);
//            host: ld_valid/ld_addr/ld_data, start, rd_req/rd_sel/rd_addr ->
//                  rd_valid/rd_data, done, err, cycles;
//            acc : conv_mem_if.slave (ready/busy, image and layer ports).
// Revision : 1.0  initial release
// ============================================================================
module conv_mem_responder
    import conv_mem_pkg::*;
#(
    parameter int DW      = CM_DW,
    parameter int IMG_AW  = CM_IMG_AW,
    parameter int L1_AW   = CM_L1_AW,
    parameter int L2_AW   = CM_L2_AW,
    parameter int TIMEOUT = CM_TIMEOUT
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              ld_valid,
    input  wire logic [IMG_AW-1:0] ld_addr,
    input  wire logic [DW-1:0]     ld_data,
    input  wire logic              start,
    input  wire logic              rd_req,
    input  wire logic [2:0]        rd_sel,
    input  wire logic [IMG_AW-1:0] rd_addr,
    output logic                   rd_valid,
    output logic      [DW-1:0]     rd_data,
    output logic                   done,
    output logic      [1:0]        err,
    output logic      [CYC_W-1:0]  cycles,
    conv_mem_if.slave              acc
);
    localparam logic [CYC_W-1:0] c_timeout    = CYC_W'(TIMEOUT);
    // Illegal code: makes rd_data read as zero after reset.
    localparam logic [2:0]       c_rd_sel_rst = 3'd7;

    state_t             r_state, w_state_nxt;
    logic               r_ready;
    logic               r_rd_valid;
    logic [2:0]         r_rd_sel;
    logic [1:0]         r_err;
    logic [CYC_W-1:0]   r_cycles;

    logic               w_host_ok, w_ld_we, w_rd_fire, w_start_ok, w_csel_ok;
    logic [CYC_W-1:0]   w_cyc_inc;
    logic               w_timeout;
    logic [DW-1:0]      w_img_ard, w_img_hrd;
    logic [DW-1:0]      w_acc_rd  [1:5];
    logic [DW-1:0]      w_host_rd [1:5];

    // Host ports are owned by the host only while the accelerator is parked.
    assign w_host_ok  = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_ld_we    = ld_valid && w_host_ok;
    assign w_rd_fire  = rd_req && w_host_ok;
    assign w_start_ok = start && w_host_ok;
    assign w_csel_ok  = (acc.csel >= CSEL_L0K0) && (acc.csel <= CSEL_L2);
    assign w_cyc_inc  = (r_cycles == '1) ? r_cycles : r_cycles + 1'b1;
    assign w_timeout  = (w_cyc_inc >= c_timeout);

    // ---------------------------------------------------------------- memories
    conv_sp_ram #(.AW(IMG_AW), .DW(DW)) u_img (
        .clk      (clk),
        .i_we     (w_ld_we),
        .i_waddr  (ld_addr),
        .i_wdata  (ld_data),
        .i_araddr (acc.iaddr),
        .o_ardata (w_img_ard),
        .i_hre    (w_rd_fire),
        .i_hraddr (rd_addr),
        .o_hrdata (w_img_hrd)
    );

    // Banks 1..5 follow the csel code; each takes only the low address bits
    // its depth needs, which is the address truncation the core relies on.
    for (genvar k = 1; k <= 5; k++) begin : g_bank
        localparam int AW_K = (k <= 2) ? IMG_AW : ((k <= 4) ? L1_AW : L2_AW);
        conv_sp_ram #(.AW(AW_K), .DW(DW)) u_ram (
            .clk      (clk),
            .i_we     (acc.cwr && (acc.csel == 3'(k))),
            .i_waddr  (acc.caddr_wr[AW_K-1:0]),
            .i_wdata  (acc.cdata_wr),
            .i_araddr (acc.caddr_rd[AW_K-1:0]),
            .o_ardata (w_acc_rd[k]),
            .i_hre    (w_rd_fire),
            .i_hraddr (rd_addr[AW_K-1:0]),
            .o_hrdata (w_host_rd[k])
        );
    end

    // ---------------------------------------------------------- state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == ST_READY);
        end
    end

    // -------------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start)     w_state_nxt = ST_READY;
            ST_READY: if (acc.busy)  w_state_nxt = ST_RUN;
            // RUN is only entered with busy high, so busy low here is a fall.
            ST_RUN:   if (!acc.busy || w_timeout) w_state_nxt = ST_DONE;
            ST_DONE:  if (start)     w_state_nxt = ST_READY;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------------------------------------- counters, flags, readback
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cycles   <= '0;
            r_err      <= 2'b00;
            r_rd_valid <= 1'b0;
            r_rd_sel   <= c_rd_sel_rst;
        end else begin
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_rd_sel <= rd_sel;
            end
            if (w_start_ok) begin
                r_cycles <= '0;
                r_err    <= 2'b00;
            end else if (r_state == ST_RUN) begin
                r_cycles <= w_cyc_inc;
                if (w_timeout && acc.busy) begin
                    r_err[1] <= 1'b1;
                end
            end
            // A bad-select write in the launch cycle still gets flagged.
            if (acc.cwr && !w_csel_ok) begin
                r_err[0] <= 1'b1;
            end
        end
    end

    // ----------------------------------------------------------------- outputs
    always_comb begin
        done      = (r_state == ST_DONE);
        acc.ready = r_ready;
        acc.idata = w_img_ard;
        rd_valid  = r_rd_valid;
        err       = r_err;
        cycles    = r_cycles;

        acc.cdata_rd = '0;
        if (acc.crd) begin
            case (acc.csel)
                CSEL_L0K0: acc.cdata_rd = w_acc_rd[1];
                CSEL_L0K1: acc.cdata_rd = w_acc_rd[2];
                CSEL_L1K0: acc.cdata_rd = w_acc_rd[3];
                CSEL_L1K1: acc.cdata_rd = w_acc_rd[4];
                CSEL_L2:   acc.cdata_rd = w_acc_rd[5];
                default:   acc.cdata_rd = '0;
            endcase
        end

        // The image has no layer-bank code, so host readback uses the
        // otherwise-empty "none" code to reach it.
        case (r_rd_sel)
            CSEL_NONE: rd_data = w_img_hrd;
            CSEL_L0K0: rd_data = w_host_rd[1];
            CSEL_L0K1: rd_data = w_host_rd[2];
            CSEL_L1K0: rd_data = w_host_rd[3];
            CSEL_L1K1: rd_data = w_host_rd[4];
            CSEL_L2:   rd_data = w_host_rd[5];
            default:   rd_data = '0;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_conv_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_mem_responder
// Purpose  : Self-checking bench for conv_mem_responder. A behavioural model
//            (plain arrays indexed modulo bank depth) predicts every read.
// Revision : 1.0  initial release
// ============================================================================
module tb_conv_mem_responder;
    import conv_mem_pkg::*;

    localparam int DW = 20;

    typedef struct {
        int sel;
        int addr;
    } loc_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              ld_valid;
    logic [11:0]       ld_addr;
    logic [DW-1:0]     ld_data;
    logic              start;
    logic              rd_req;
    logic [2:0]        rd_sel;
    logic [11:0]       rd_addr;
    logic              rd_valid;
    logic [DW-1:0]     rd_data;
    logic              done;
    logic [1:0]        err;
    logic [CYC_W-1:0]  cycles;

    conv_mem_if #(.DW(DW), .AW(12)) acc_if ();

    conv_mem_responder #(
        .DW(DW), .IMG_AW(12), .L1_AW(10), .L2_AW(11), .TIMEOUT(100)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .start    (start),
        .rd_req   (rd_req),
        .rd_sel   (rd_sel),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .done     (done),
        .err      (err),
        .cycles   (cycles),
        .acc      (acc_if.slave)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_errs   = 0;
    logic [DW-1:0] m_img  [0:4095];
    logic [DW-1:0] m_bank [1:5][0:4095];
    loc_t          written[$];
    int            img_written[$];

    function automatic int bank_words(input int sel);
        if (sel <= 2) return 4096;
        if (sel <= 4) return 1024;
        return 2048;
    endfunction

    function automatic logic [DW-1:0] exp_layer(input int sel, input int addr);
        if (sel < 1 || sel > 5) return '0;
        return m_bank[sel][addr % bank_words(sel)];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc_write(input int sel, input int addr, input logic [DW-1:0] d);
        acc_if.cwr      = 1'b1;
        acc_if.csel     = sel[2:0];
        acc_if.caddr_wr = addr[11:0];
        acc_if.cdata_wr = d;
        tick();
        acc_if.cwr = 1'b0;
        if (sel >= 1 && sel <= 5) begin
            m_bank[sel][addr % bank_words(sel)] = d;
            written.push_back('{sel, addr});
        end
    endtask

    task automatic img_load(input int addr, input logic [DW-1:0] d);
        ld_valid = 1'b1;
        ld_addr  = addr[11:0];
        ld_data  = d;
        tick();
        ld_valid = 1'b0;
        m_img[addr] = d;
        img_written.push_back(addr);
    endtask

    task automatic host_read(input string tag, input int sel, input int addr, input logic [DW-1:0] exp);
        rd_req  = 1'b1;
        rd_sel  = sel[2:0];
        rd_addr = addr[11:0];
        tick();
        rd_req = 1'b0;
        check_eq({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        check_eq({tag, "_data"}, {12'd0, rd_data}, {12'd0, exp});
    endtask

    task automatic acc_read(input string tag, input int sel, input int addr);
        acc_if.crd      = 1'b1;
        acc_if.csel     = sel[2:0];
        acc_if.caddr_rd = addr[11:0];
        #1;
        check_eq(tag, {12'd0, acc_if.cdata_rd}, {12'd0, exp_layer(sel, addr)});
        acc_if.crd = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        loc_t          loc;
        int            n;
        logic [DW-1:0] d_old, d_new;

        reset = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0;
        rd_req = 1'b0; rd_sel = '0; rd_addr = '0;
        acc_if.busy = 1'b0; acc_if.iaddr = '0; acc_if.csel = '0; acc_if.cwr = 1'b0;
        acc_if.caddr_wr = '0; acc_if.cdata_wr = '0; acc_if.crd = 1'b0; acc_if.caddr_rd = '0;
        repeat (3) tick();

        // Reset state
        check_eq("rst_ready",    {31'd0, acc_if.ready}, 32'd0);
        check_eq("rst_done",     {31'd0, done}, 32'd0);
        check_eq("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check_eq("rst_err",      {30'd0, err}, 32'd0);
        check_eq("rst_cycles",   {12'd0, cycles}, 32'd0);
        check_eq("rst_rd_data",  {12'd0, rd_data}, 32'd0);
        reset = 1'b1;
        tick();

        // Image load: random fill then the two corner words
        for (int i = 0; i < 12; i++) begin
            img_load($urandom_range(1, 4094), DW'($urandom));
        end
        img_load(0, 20'h0A89E);
        img_load(4095, 20'hFFFFF);
        acc_if.iaddr = 12'd0;    #1;
        check_eq("idata_0",    {12'd0, acc_if.idata}, 32'h0A89E);
        acc_if.iaddr = 12'd4095; #1;
        check_eq("idata_4095", {12'd0, acc_if.idata}, 32'hFFFFF);
        for (int i = 0; i < 6; i++) begin
            n = img_written[$urandom_range(0, img_written.size() - 1)];
            acc_if.iaddr = n[11:0]; #1;
            check_eq("idata_rand", {12'd0, acc_if.idata}, {12'd0, m_img[n]});
        end

        // Layer banks: every bank at 1023, then random addresses (incl. aliasing)
        for (int s = 1; s <= 5; s++) acc_write(s, 1023, DW'($urandom));
        for (int i = 0; i < 20; i++) acc_write($urandom_range(1, 5), $urandom_range(0, 4095), DW'($urandom));
        for (int i = 0; i < 8; i++) begin
            loc = written[$urandom_range(0, written.size() - 1)];
            acc_read("cdata_rd_rand", loc.sel, loc.addr);
        end
        acc_if.crd = 1'b0; acc_if.csel = 3'd3; acc_if.caddr_rd = 12'd1023; #1;
        check_eq("cdata_rd_crd0", {12'd0, acc_if.cdata_rd}, 32'd0);

        // Back-to-back host readback, one result per cycle
        rd_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            loc     = written[$urandom_range(0, written.size() - 1)];
            rd_sel  = loc.sel[2:0];
            rd_addr = loc.addr[11:0];
            tick();
            check_eq("b2b_valid", {31'd0, rd_valid}, 32'd1);
            check_eq("b2b_data",  {12'd0, rd_data}, {12'd0, exp_layer(loc.sel, loc.addr)});
        end
        rd_req = 1'b0;
        tick();
        check_eq("b2b_valid_end", {31'd0, rd_valid}, 32'd0);
        host_read("rd_illegal", 6, 1023, '0);

        // Same-cycle read and write to the same word shows the old value
        d_old = exp_layer(5, 1023);
        d_new = ~d_old;
        acc_if.cwr = 1'b1; acc_if.csel = 3'd5; acc_if.caddr_wr = 12'd1023; acc_if.cdata_wr = d_new;
        acc_if.crd = 1'b1; acc_if.caddr_rd = 12'd1023; #1;
        check_eq("rw_same_old", {12'd0, acc_if.cdata_rd}, {12'd0, d_old});
        tick();
        acc_if.cwr = 1'b0;
        m_bank[5][1023] = d_new;
        #1;
        check_eq("rw_same_new", {12'd0, acc_if.cdata_rd}, {12'd0, d_new});
        acc_if.crd = 1'b0;

        // Illegal-select write changes nothing and flags err[0]
        acc_write(6, 1023, 20'h5A5A5);
        check_eq("err_illegal", {30'd0, err}, 32'd1);
        for (int s = 1; s <= 5; s++) host_read("illegal_nochange", s, 1023, exp_layer(s, 1023));

        // Run: three READY cycles, 50 busy cycles, done
        start = 1'b1; tick(); start = 1'b0;
        check_eq("start_err_clr", {30'd0, err}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check_eq("ready_wait", {31'd0, acc_if.ready}, 32'd1);
            tick();
        end
        check_eq("ready_last", {31'd0, acc_if.ready}, 32'd1);
        acc_if.busy = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (i == 0) check_eq("ready_drop", {31'd0, acc_if.ready}, 32'd0);
            if (i == 5) begin
                acc_if.cwr = 1'b1; acc_if.csel = 3'd3; acc_if.caddr_wr = 12'd1023; acc_if.cdata_wr = 20'h00123;
            end
            if (i == 6) begin
                acc_if.cwr = 1'b0;
                m_bank[3][1023] = 20'h00123;
                acc_read("run_cdata_rd", 3, 1023);
            end
            if (i == 10) begin
                rd_req = 1'b1; rd_sel = 3'd3; rd_addr = 12'd1023;
                ld_valid = 1'b1; ld_addr = 12'd0; ld_data = 20'h55555;
            end
            if (i == 11) begin
                rd_req = 1'b0; ld_valid = 1'b0;
                check_eq("run_rd_ignored", {31'd0, rd_valid}, 32'd0);
            end
        end
        acc_if.busy = 1'b0;
        tick();
        check_eq("run_done",   {31'd0, done}, 32'd1);
        check_eq("run_cycles", {12'd0, cycles}, 32'd50);
        check_eq("run_err",    {30'd0, err}, 32'd0);
        acc_if.iaddr = 12'd0; #1;
        check_eq("run_ld_ignored", {12'd0, acc_if.idata}, 32'h0A89E);
        host_read("done_readback", 3, 1023, 20'h00123);

        // Sticky err[0] cleared by the next start
        acc_write(7, 5, 20'h11111);
        check_eq("err_sticky", {30'd0, err}, 32'd1);
        start = 1'b1; tick(); start = 1'b0;
        check_eq("restart_err",    {30'd0, err}, 32'd0);
        check_eq("restart_done",   {31'd0, done}, 32'd0);
        check_eq("restart_cycles", {12'd0, cycles}, 32'd0);
        check_eq("restart_ready",  {31'd0, acc_if.ready}, 32'd1);

        // Timeout with busy stuck high
        acc_if.busy = 1'b1;
        tick();
        n = 0;
        while (!done && n < 150) begin
            tick();
            n++;
        end
        check_eq("to_run_len", n, 32'd100);
        check_eq("to_done",    {31'd0, done}, 32'd1);
        check_eq("to_err",     {30'd0, err}, 32'd2);
        check_eq("to_cycles",  {12'd0, cycles}, 32'd100);
        acc_if.busy = 1'b0;
        tick();

        // Reset in the middle of a run
        start = 1'b1; tick(); start = 1'b0;
        acc_if.busy = 1'b1;
        repeat (4) tick();
        reset = 1'b0;
        tick();
        check_eq("mid_rst_ready",  {31'd0, acc_if.ready}, 32'd0);
        check_eq("mid_rst_done",   {31'd0, done}, 32'd0);
        check_eq("mid_rst_cycles", {12'd0, cycles}, 32'd0);
        check_eq("mid_rst_err",    {30'd0, err}, 32'd0);
        reset = 1'b1; acc_if.busy = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            n = img_written[$urandom_range(0, img_written.size() - 1)];
            acc_if.iaddr = n[11:0]; #1;
            check_eq("img_kept", {12'd0, acc_if.idata}, {12'd0, m_img[n]});
        end

        // Image load and readback in the same cycle, after reset (IDLE)
        d_new = DW'($urandom);
        loc   = written[$urandom_range(0, written.size() - 1)];
        ld_valid = 1'b1; ld_addr = 12'd7; ld_data = d_new;
        rd_req = 1'b1; rd_sel = loc.sel[2:0]; rd_addr = loc.addr[11:0];
        tick();
        ld_valid = 1'b0; rd_req = 1'b0;
        m_img[7] = d_new;
        check_eq("dual_rd_valid", {31'd0, rd_valid}, 32'd1);
        check_eq("dual_rd_data",  {12'd0, rd_data}, {12'd0, exp_layer(loc.sel, loc.addr)});
        acc_if.iaddr = 12'd7; #1;
        check_eq("dual_ld", {12'd0, acc_if.idata}, {12'd0, d_new});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
`default_nettype wire
